// File: rtl/cla_seq_ctrl_if.sv
// Handshake and operand/result bus for the nibble-serial CLA adder.
interface cla_seq_ctrl_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   result;
    logic             ovf;
    logic             busy;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, result, ovf, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, result, ovf, busy
    );
endinterface

// File: rtl/cla_seq_ctrl.sv
// Sequential adder: one 4-bit carry-lookahead slice reused over WIDTH/4 cycles,
// with valid/ready handshakes on both sides and signed-overflow detection.
module cla_seq_ctrl #(
    parameter int unsigned WIDTH = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    cla_seq_ctrl_if.slave  bus
);
    localparam int unsigned NIB = WIDTH / 4;
    localparam int unsigned IW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIB - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH:0]   result_q, result_d;
    logic             ovf_q, ovf_d;
    logic             in_ready_q, out_valid_q, busy_q;

    logic [3:0] nib_a, nib_b, g, p, s;
    logic [4:0] c;

    // Carry-lookahead slice on the current nibble: every carry from g/p and carry_q.
    always_comb begin
        nib_a = a_q[{idx_q, 2'b00} +: 4];
        nib_b = b_q[{idx_q, 2'b00} +: 4];
        g     = nib_a & nib_b;
        p     = nib_a ^ nib_b;
        c[0]  = carry_q;
        c[1]  = g[0] | (p[0] & carry_q);
        c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_q);
        c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & carry_q);
        c[4]  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & carry_q);
        s     = p ^ c[3:0];
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sum_d    = sum_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = bus.cin;
                    sum_d   = '0;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[{idx_q, 2'b00} +: 4] = s;
                carry_d = c[4];
                idx_d   = IW'(idx_q + 1'b1);
                if (idx_q == LAST) begin
                    // Top nibble: overflow compares carry into and out of the MSB.
                    result_d = {c[4], sum_d};
                    ovf_d    = c[3] ^ c[4];
                    idx_d    = '0;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            result_q    <= result_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
            busy_q      <= (state_d == RUN);
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.result    = result_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: doc/cla_seq_ctrl.md
CLA_SEQ_CTRL -- requirements
Module: cla_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits; legal values are multiples of 4 that are at least 8.
REQ-002 SHALL have localparam NIB, value WIDTH/4, number of nibble steps per operation.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: operands and carry-in are presented.
REQ-006 SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-007 SHALL have port a, input, WIDTH bits, first addend.
REQ-008 SHALL have port b, input, WIDTH bits, second addend.
REQ-009 SHALL have port cin, input, 1 bit, carry-in.
REQ-010 SHALL have port out_valid, output, 1 bit: result is presented.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-012 SHALL have port result, output, WIDTH+1 bits: {carry-out, sum}.
REQ-013 SHALL have port ovf, output, 1 bit: two's-complement signed overflow of the sum.
REQ-014 SHALL have port busy, output, 1 bit: high in RUN state.

Function
REQ-015 SHALL implement FSM states IDLE, RUN and DONE.
REQ-016 in_ready SHALL be 1 exactly when state is IDLE; out_valid SHALL be 1 exactly when state is DONE; busy SHALL be 1 exactly when state is RUN.
REQ-017 Accept: on an edge in IDLE with in_valid=1, SHALL register a, b and cin, clear the sum register, set nibble index 0 and go to RUN.
REQ-018 IDLE with in_valid=0 SHALL hold all state.
REQ-019 RUN, each edge, nibble index i SHALL be processed as {c,s} = a[4i+3:4i] + b[4i+3:4i] + carry, using a 4-bit carry-lookahead slice (generate/propagate terms, no ripple).
REQ-020 RUN, each edge: s SHALL be written to sum bits [4i+3:4i], carry SHALL be updated to c, and i SHALL be incremented.
REQ-021 On the step with i = NIB-1, SHALL go to DONE, store the final carry, and set ovf = (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1).
REQ-022 Latency SHALL be exactly NIB cycles: out_valid rises NIB edges after the accepting edge (4 for WIDTH=16).
REQ-023 DONE: result and ovf SHALL be held stable while out_ready=0.
REQ-024 DONE: on an edge with out_ready=1, SHALL return to IDLE; result and ovf SHALL keep their last values.
REQ-025 in_valid, a, b and cin SHALL be ignored outside IDLE; registered operands SHALL NOT change during RUN.
REQ-026 No overlap: a new accept SHALL occur no earlier than the edge after DONE exits, giving a minimum initiation interval of NIB+2 cycles.
REQ-027 out_ready SHALL be ignored outside DONE.
REQ-028 Arithmetic SHALL be unsigned modulo 2^(WIDTH+1); result SHALL equal a + b + cin exactly.

Reset
REQ-029 rst_n=0 SHALL immediately, without waiting for a clock edge, force state IDLE, nibble index 0, carry 0, result 0 and ovf 0.
REQ-030 Reset outputs SHALL be in_ready=1, out_valid=0, busy=0, result=0, ovf=0.
REQ-031 Reset asserted in any state, including mid-RUN or in DONE with out_valid high, SHALL abort the operation with no partial result retained.
REQ-032 After rst_n deassertion, the first rising edge with in_valid=1 SHALL be a valid accept.

Verification
REQ-033 Carry chain: a=16'hFFFF, b=16'h0001, cin=0 -> result=17'h10000, ovf=0, out_valid exactly 4 cycles after accept.
REQ-034 Signed overflow: a=16'h7FFF, b=16'h0001, cin=0 -> result=17'h08000, ovf=1; and a=16'h8000, b=16'h8000 -> result=17'h10000, ovf=1.
REQ-035 Carry-in: a=16'h000C, b=16'h00C8, cin=1 -> result=17'h000D5, ovf=0; a=16'hFFFF, b=16'h0000, cin=1 -> result=17'h10000.
REQ-036 Backpressure: hold out_ready=0 for 3 cycles in DONE while changing a, b and in_valid -> result stable, in_ready=0, no new accept; the operation completes when out_ready=1.
REQ-037 Reset mid-operation: assert rst_n=0 between edges 2 and 3 of RUN -> outputs reset immediately; the next operation a=16'h1234, b=16'h4321 gives result=17'h05555.
REQ-038 Back-to-back: in_valid held high with out_ready=1 -> accepts spaced exactly 6 cycles apart (WIDTH=16), all results correct.
